fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock synchronous FIFO; next generation of the 8-bit/8-deep FIFO.
//  Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty
//  thresholds, and sticky overflow/underflow error flags. Used as the generic buffer
//  between producer/consumer blocks on one clock domain.
// PARAMETERS
//  WIDTH     8   data word width in bits (>=1)
//  DEPTH     8   number of entries; power of two, >=2
//  AF_LEVEL  6   almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  1   almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          synchronous reset, active-high
//  wr            in   1          write request
//  d_in          in   WIDTH      write data, sampled at clk edge when write accepted
//  rd            in   1          read request
//  d_out         out  WIDTH      registered read data
//  full          out  1          count == DEPTH
//  empty         out  1          count == 0
//  almost_full   out  1          count >= AF_LEVEL
//  almost_empty  out  1          count <= AE_LEVEL
//  count         out  AW+1       occupancy, AW = clog2(DEPTH)
//  overflow      out  1          sticky: write rejected since last clear
//  underflow     out  1          sticky: read rejected since last clear
//  clr_err       in   1          synchronous clear of overflow/underflow
// BEHAVIOUR
//  - Reset (rst=1 at edge): wptr=rptr=0, count=0, d_out=0, overflow=underflow=0;
//    hence empty=1, full=0, almost_empty=1, almost_full=0. Memory contents not cleared.
//    Reset mid-operation discards all stored data; rst has priority over all inputs.
//  - rd_acc = rd & ~empty;  wr_acc = wr & (~full | rd_acc).
//  - Write: on wr_acc, mem[wptr[AW-1:0]] <= d_in, wptr <= wptr+1.
//  - Read: on rd_acc, d_out <= mem[rptr[AW-1:0]], rptr <= rptr+1. Latency 1: data for a read
//    issued in cycle N is on d_out after edge N. d_out holds its value when no read is accepted.
//  - count <= count + wr_acc - rd_acc; all flags decode from registered count/pointers (no
//    combinational path from wr/rd to flags).
//  - Pointers are AW+1 bits; the MSB toggles on wrap. full = (wptr^rptr)=={1,0..0};
//    empty = wptr==rptr. Wrap-around is seamless; ordering is strict FIFO.
//  - Simultaneous wr&rd: 0<count<DEPTH -> both accepted, count unchanged.
//    count==DEPTH -> read frees slot, write also accepted, count stays DEPTH, no overflow.
//    count==0 -> write accepted, read rejected (underflow set), count becomes 1.
//  - overflow <= 1 when wr & ~wr_acc; underflow <= 1 when rd & ~rd_acc. Cleared only by
//    rst or clr_err; if clr_err and a new error coincide, the error wins (flag stays 1).
//  - Rejected accesses never modify pointers, memory or d_out.
// STRUCTURE
//  - Shared package fifo_pkg: clog2 function, default WIDTH/DEPTH constants, and an elaboration
//    check (DEPTH power of two, AE_LEVEL < AF_LEVEL <= DEPTH).
//  - Sub-module fifo_ram_sdp: simple dual-port RAM, WIDTH x DEPTH, sync write and sync read
//    (registered output = d_out). Top holds pointers, count, flags and error logic.
// TESTING (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1)
//  1. rst=1 for 2 edges -> empty=1 full=0 count=0 d_out=0 almost_empty=1 overflow=underflow=0.
//  2. Write 8'h11..8'h88 (8 writes) -> almost_empty drops at count 2, almost_full rises at 6,
//     full=1 at 8; 9th write of 8'hFF -> overflow=1, count stays 8.
//  3. Read 8 -> d_out 8'h11..8'h88 in order, each one edge after rd; empty=1 after 8th;
//     9th rd -> underflow=1, d_out holds 8'h88; clr_err pulse -> both flags 0.
//  4. Simultaneous wr&rd at count 4 (count unchanged, order kept), at full (no overflow, count 8),
//     at empty (count 1, underflow=1, d_out unchanged).
//  5. 40 random interleaved wr/rd cycles spanning 3+ pointer wraps -> scoreboard match, count
//     equals model every cycle.
//  6. Write 5 words, assert rst mid-stream -> count=0 empty=1 next cycle; following rd -> underflow=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: default sizes, a constant
// log2 helper and the parameter legality check used at elaboration.
package fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;

   // Ceiling log2, usable in constant expressions such as port widths.
   function automatic int clog2(input int value);
      int result;
      int span;
      result = 0;
      span   = value - 1;
      while (span > 0) begin
         result = result + 1;
         span   = span >> 1;
      end
      return result;
   endfunction

   function automatic bit paramsValid(input int depth, input int afLevel, input int aeLevel);
      return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
             (aeLevel >= 0) && (aeLevel < afLevel) && (afLevel <= depth);
   endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM with synchronous write and registered synchronous read.
// The read register only changes on an enabled read, so it doubles as the FIFO output.
module fifo_ram_sdp #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // Storage is never reset; only the pointers in the parent define what is valid.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Same-address read and write in one cycle returns the old word, which is
   // exactly the oldest entry when a full FIFO is read and written together.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wr,
   input  logic [WIDTH-1:0]      i_d_in,
   input  logic                  i_rd,
   input  logic                  i_clr_err,
   output logic [WIDTH-1:0]      o_d_out,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic [clog2(DEPTH):0] o_count,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int          AW       = clog2(DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);
   localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);
   localparam logic [AW:0] WRAP_XOR = {1'b1, {AW{1'b0}}};

   generate
      if (!paramsValid(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_badParams
         $error("fifo_sync_param: DEPTH must be a power of two and AE_LEVEL < AF_LEVEL <= DEPTH");
      end
   endgenerate

   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic [AW:0] r_count;
   logic        r_overflow;
   logic        r_underflow;

   logic        w_full;
   logic        w_empty;
   logic        w_rdAcc;
   logic        w_wrAcc;

   // Flags come only from registered pointers so no request reaches them combinationally.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = ((r_wptr ^ r_rptr) == WRAP_XOR);
   assign w_rdAcc = i_rd & ~w_empty;
   assign w_wrAcc = i_wr & (~w_full | w_rdAcc);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wrAcc) begin
            r_wptr <= r_wptr + ONE;
         end
         if (w_rdAcc) begin
            r_rptr <= r_rptr + ONE;
         end
         case ({w_wrAcc, w_rdAcc})
            2'b10:   r_count <= r_count + ONE;
            2'b01:   r_count <= r_count - ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // A fresh error in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (i_wr & ~w_wrAcc) begin
            r_overflow <= 1'b1;
         end else if (i_clr_err) begin
            r_overflow <= 1'b0;
         end
         if (i_rd & ~w_rdAcc) begin
            r_underflow <= 1'b1;
         end else if (i_clr_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   fifo_ram_sdp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_wrAcc),
      .i_waddr (r_wptr[AW-1:0]),
      .i_wdata (i_d_in),
      .i_re    (w_rdAcc),
      .i_raddr (r_rptr[AW-1:0]),
      .o_rdata (o_d_out)
   );

   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (r_count >= AF_CNT);
   assign o_almost_empty = (r_count <= AE_CNT);
   assign o_count        = r_count;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule
